// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small transmit FIFO in front of a
// start/data/stop frame sequencer.
//
// state | meaning
// IDLE  | line high, waiting for a queued byte
// START | driving the start bit (0)
// DATA  | shifting out 8 data bits, LSB first
// STOP  | driving the stop bit (1)
module uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [7:0]                       tx_data,
  input  logic                             tx_valid,
  output logic                             tx_ready,
  output logic                             io_tx,
  output logic                             busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          io_tx_q, io_tx_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    mem_q [FIFO_DEPTH];

  logic push;
  logic pop;
  logic baud_done;
  logic fifo_empty;
  logic [7:0] fifo_head;

  assign tx_ready   = (count_q != CW'(FIFO_DEPTH));
  assign push       = tx_valid && tx_ready;
  assign fifo_empty = (count_q == '0);
  assign fifo_head  = mem_q[rd_ptr_q];
  assign baud_done  = (baud_q == BAUD_LAST);

  assign io_tx      = io_tx_q;
  assign fifo_count = count_q;
  assign busy       = (state_q != S_IDLE) || !fifo_empty;

  // Storage is not reset; only pointers and count define FIFO contents.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= tx_data;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    io_tx_d   = io_tx_q;
    pop       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        io_tx_d = 1'b1;
        baud_d  = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_head;
          state_d = S_START;
          io_tx_d = 1'b0;
        end
      end

      S_START: begin
        if (baud_done) begin
          baud_d    = '0;
          bit_idx_d = 3'd0;
          state_d   = S_DATA;
          io_tx_d   = shift_q[0];
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end

      S_DATA: begin
        if (baud_done) begin
          baud_d = '0;
          // Shifting right keeps the next bit in shift_q[1] at each boundary.
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
            io_tx_d = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            io_tx_d   = shift_q[1];
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end

      S_STOP: begin
        if (baud_done) begin
          baud_d = '0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_head;
            state_d = S_START;
            io_tx_d = 1'b0;
          end else begin
            state_d = S_IDLE;
            io_tx_d = 1'b1;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        io_tx_d = 1'b1;
        baud_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      io_tx_q   <= 1'b1;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      io_tx_q   <= io_tx_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, meaning clk cycles per serial bit (100 MHz / 115200 baud); SHALL be >= 2.
REQ-002 Parameter FIFO_DEPTH, default 16, meaning transmit FIFO entries; SHALL be a power of 2, >= 2.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 Port `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port `reset_n`, input, 1 bit: asynchronous active-low reset.
REQ-006 Port `tx_data`, input, 8 bits: byte offered for transmission.
REQ-007 Port `tx_valid`, input, 1 bit: `tx_data` is valid.
REQ-008 Port `tx_ready`, output, 1 bit: FIFO can accept a byte.
REQ-009 Port `io_tx`, output, 1 bit: serial line, registered; idle high.
REQ-010 Port `busy`, output, 1 bit: the FIFO is non-empty or a frame is in progress.
REQ-011 Port `fifo_count`, output, $clog2(FIFO_DEPTH+1) bits: current FIFO occupancy.

Function
REQ-012 Frame format SHALL be 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1), no parity.
REQ-013 Each bit SHALL drive `io_tx` for exactly CLKS_PER_BIT cycles; a frame lasts 10*CLKS_PER_BIT cycles.
REQ-014 A byte SHALL be accepted on a rising edge where `tx_valid` && `tx_ready`; `tx_data` is ignored otherwise.
REQ-015 `tx_ready` SHALL equal !full, combinationally from FIFO state only and independent of `tx_valid`.
REQ-016 The FIFO SHALL be first-in first-out with wrap-around read/write pointers.
REQ-017 Push and pop on the same edge SHALL leave `fifo_count` unchanged.
REQ-018 Push while full cannot occur, because `tx_ready` is 0; pop while empty SHALL not occur.
REQ-019 The FSM SHALL have four states: IDLE, START, DATA, STOP.
REQ-020 IDLE -> START SHALL occur on the first edge in IDLE with the FIFO non-empty; that edge pops the head into the shift register.
REQ-021 START -> DATA SHALL occur after CLKS_PER_BIT cycles.
REQ-022 DATA SHALL shift out 8 bits using a 3-bit index counter, then go to STOP.
REQ-023 At the end of STOP, with the FIFO non-empty, the FSM SHALL pop and go directly to START, with no idle gap between frames.
REQ-024 At the end of STOP, with the FIFO empty, the FSM SHALL go to IDLE.
REQ-025 Latency: for a handshake at edge N with the FIFO empty and the FSM in IDLE, the pop SHALL occur at edge N+1 and `io_tx` SHALL go low after edge N+1.
REQ-026 The baud counter SHALL count 0..CLKS_PER_BIT-1 and reset to 0 on every state or bit change.
REQ-027 `busy` SHALL be high when state != IDLE or `fifo_count` != 0.

Reset
REQ-028 While `reset_n` is low: `io_tx`=1, `fifo_count`=0, `busy`=0, `tx_ready`=1, FSM=IDLE, pointers=0, baud counter=0.
REQ-029 Reset asserted mid-frame SHALL immediately force `io_tx` high and discard the frame in progress and all queued bytes.
REQ-030 After `reset_n` rises, the first handshake SHALL behave exactly as in REQ-025.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-031 Single byte 0xA5 accepted at edge 0: `io_tx` low from edge 1, then 1,0,1,0,0,1,0,1 (4 cycles each), then stop high for 4 cycles. `busy` SHALL fall at edge 41.
REQ-032 `tx_valid` held high for 6 consecutive bytes B0..B5:
- B0..B4 accepted at edges 0..4; `fifo_count`=4 and `tx_ready`=0 after edge 4.
- B5 held until edge 41, where B1 is popped and B5 accepted on the same edge.
- Six contiguous frames on `io_tx` with no gaps.
REQ-033 Back-to-back 0x00 then 0xFF: the stop bit of frame 1 lasts exactly 4 cycles, and the start bit of frame 2 follows immediately.
REQ-034 `tx_data` changing while `tx_ready`=0: no byte is accepted, `fifo_count` is unchanged, and transmitted bytes match the accepted values only.
REQ-035 `reset_n` pulsed low during DATA of 0x3C with 2 bytes queued: `io_tx`=1 and `fifo_count`=0 immediately. After release, `io_tx` stays idle high until a new handshake, and 0x3C is never completed.
